// File: rtl/trinity_selection_unit_if.sv
// Offspring-in / parent-pair-out bus of the selection unit, plus its status outputs.
interface trinity_selection_unit_if #(
    parameter int W       = 64,
    parameter int SCORE_W = 32,
    parameter int IDX_W   = 3
);
    logic               child_valid;
    logic               child_ready;
    logic [W-1:0]       child_weights;
    logic [SCORE_W-1:0] child_score;
    logic               parent_valid;
    logic               parent_ready;
    logic [W-1:0]       parent_weights_a;
    logic [W-1:0]       parent_weights_b;
    logic [W-1:0]       best_weights;
    logic [SCORE_W-1:0] best_score;
    logic [IDX_W:0]     pop_count;

    modport slave (
        input  child_valid, child_weights, child_score, parent_ready,
        output child_ready, parent_valid, parent_weights_a, parent_weights_b,
               best_weights, best_score, pop_count
    );
    modport master (
        output child_valid, child_weights, child_score, parent_ready,
        input  child_ready, parent_valid, parent_weights_a, parent_weights_b,
               best_weights, best_score, pop_count
    );
endinterface

// File: rtl/trinity_selection_unit.sv
// Population store with worst-member replacement, LFSR-driven 2-way tournaments
// and best-ever tracking for the evolution loop.
module trinity_selection_unit #(
    parameter int          POP_SIZE  = 8,
    parameter int          IDX_W     = 3,
    parameter int          W         = 64,
    parameter int          SCORE_W   = 32,
    parameter logic [31:0] LFSR_SEED = 32'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    trinity_selection_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SCAN, REPLACE, SEL_A, SEL_B, OFFER} state_t;

    localparam logic [IDX_W:0]   FULL = (IDX_W+1)'(POP_SIZE);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(POP_SIZE - 1);

    state_t             r_state, w_next;
    logic [W-1:0]       r_pop_w [POP_SIZE];
    logic [SCORE_W-1:0] r_pop_s [POP_SIZE];
    logic [IDX_W:0]     r_count;
    logic [31:0]        r_lfsr;
    logic [IDX_W-1:0]   r_scan_idx, r_min_idx;
    logic [SCORE_W-1:0] r_min_s, r_child_s, r_best_s;
    logic [W-1:0]       r_child_w, r_par_a, r_par_b, r_best_w;

    logic [W-1:0]       w_san, w_wr_w;
    logic [SCORE_W-1:0] w_wr_s;
    logic [IDX_W-1:0]   w_wr_idx, w_i1, w_i2, w_win;
    logic               w_full, w_ready, w_accept, w_wr_en;

    // Illegal trit code 2'b11 is folded to zero before it can enter the population.
    for (genvar t = 0; t < W/2; t++) begin : g_san
        assign w_san[2*t +: 2] = (bus.child_weights[2*t +: 2] == 2'b11) ? 2'b01
                                                                         : bus.child_weights[2*t +: 2];
    end

    assign w_full   = (r_count == FULL);
    assign w_ready  = (r_state == IDLE) && !reset;
    assign w_accept = bus.child_valid && w_ready;

    assign w_i1  = r_lfsr[IDX_W-1:0];
    assign w_i2  = r_lfsr[2*IDX_W-1:IDX_W];
    assign w_win = (r_pop_s[w_i2] > r_pop_s[w_i1]) ? w_i2 : w_i1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) begin
                         if (w_full) w_next = SCAN;
                     end else if (w_full) begin
                         w_next = SEL_A;
                     end
            SCAN:    if (r_scan_idx == LAST) w_next = REPLACE;
            REPLACE: w_next = IDLE;
            SEL_A:   w_next = SEL_B;
            SEL_B:   w_next = OFFER;
            OFFER:   if (bus.parent_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Single write port shared by direct fill and replacement.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_count[IDX_W-1:0];
        w_wr_w   = w_san;
        w_wr_s   = bus.child_score;
        if (w_accept && !w_full) begin
            w_wr_en = 1'b1;
        end else if (r_state == REPLACE && r_child_s > r_min_s) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_min_idx;
            w_wr_w   = r_child_w;
            w_wr_s   = r_child_s;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_pop_w[w_wr_idx] <= w_wr_w;
            r_pop_s[w_wr_idx] <= w_wr_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_lfsr     <= LFSR_SEED;
            r_scan_idx <= '0;
            r_min_idx  <= '0;
            r_min_s    <= '0;
            r_child_w  <= '0;
            r_child_s  <= '0;
            r_par_a    <= '0;
            r_par_b    <= '0;
            r_best_w   <= '0;
            r_best_s   <= '0;
        end else begin
            r_state <= w_next;
            r_lfsr  <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
            if (w_wr_en && (r_count == '0 || w_wr_s > r_best_s)) begin
                r_best_w <= w_wr_w;
                r_best_s <= w_wr_s;
            end
            case (r_state)
                IDLE: if (w_accept) begin
                    if (!w_full) begin
                        r_count <= r_count + 1'b1;
                    end else begin
                        r_child_w  <= w_san;
                        r_child_s  <= bus.child_score;
                        r_scan_idx <= '0;
                    end
                end
                SCAN: begin
                    // Strict less-than keeps the lowest index on ties.
                    if (r_scan_idx == '0 || r_pop_s[r_scan_idx] < r_min_s) begin
                        r_min_s   <= r_pop_s[r_scan_idx];
                        r_min_idx <= r_scan_idx;
                    end
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
                SEL_A:   r_par_a <= r_pop_w[w_win];
                SEL_B:   r_par_b <= r_pop_w[w_win];
                default: ;
            endcase
        end
    end

    assign bus.child_ready      = w_ready;
    assign bus.parent_valid     = (r_state == OFFER);
    assign bus.parent_weights_a = r_par_a;
    assign bus.parent_weights_b = r_par_b;
    assign bus.best_weights     = r_best_w;
    assign bus.best_score       = r_best_s;
    assign bus.pop_count        = r_count;
endmodule

// File: tb/tb_trinity_selection_unit.sv
// Directed bench for trinity_selection_unit: fill table, replacement corner
// cases, tournament handshake against a reference LFSR, and mid-scan reset.
module tb_trinity_selection_unit;
    localparam int W = 64, SW = 32, IW = 3, PS = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    trinity_selection_unit_if #(.W(W), .SCORE_W(SW), .IDX_W(IW)) bus ();

    trinity_selection_unit #(
        .POP_SIZE(PS), .IDX_W(IW), .W(W), .SCORE_W(SW), .LFSR_SEED(32'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] m_lfsr;
    always @(posedge clk)
        m_lfsr <= reset ? 32'hACE1 : {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};

    logic [63:0] m_w [PS];
    logic [31:0] m_s [PS];

    typedef struct {
        logic [63:0] w;
        logic [31:0] s;
        logic [3:0]  cnt;
        logic [31:0] bs;
        logic [63:0] bw;
    } vec_t;
    vec_t tbl [PS];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pick(input logic [31:0] l);
        logic [2:0] a, b;
        a = l[2:0];
        b = l[5:3];
        return (m_s[b] > m_s[a]) ? m_w[b] : m_w[a];
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!bus.child_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_bound", 64'(n < 50), 64'd1);
    endtask

    task automatic send_child(input logic [63:0] w, input logic [31:0] s);
        bus.child_valid   = 1'b1;
        bus.child_weights = w;
        bus.child_score   = s;
        wait_idle();
        @(negedge clk);
        bus.child_valid = 1'b0;
    endtask

    // Called on an IDLE cycle with a full population.
    task automatic do_select();
        logic [31:0] la, lb;
        logic [63:0] ea, eb;
        bus.parent_ready = 1'b0;
        @(negedge clk); chk("sel_a_no_valid", 64'(bus.parent_valid), 64'd0); la = m_lfsr;
        @(negedge clk); chk("sel_b_no_valid", 64'(bus.parent_valid), 64'd0); lb = m_lfsr;
        @(negedge clk);
        ea = pick(la);
        eb = pick(lb);
        chk("offer_valid", 64'(bus.parent_valid), 64'd1);
        chk("parent_a", bus.parent_weights_a, ea);
        chk("parent_b", bus.parent_weights_b, eb);
        bus.child_valid   = 1'b1;
        bus.child_weights = 64'h0000_0000_0000_1000;
        bus.child_score   = 32'd1000;
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.parent_valid), 64'd1);
            chk("hold_a", bus.parent_weights_a, ea);
            chk("hold_b", bus.parent_weights_b, eb);
            chk("hold_no_child", 64'(bus.child_ready), 64'd0);
        end
        bus.child_valid  = 1'b0;
        bus.parent_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", 64'(bus.parent_valid), 64'd0);
        chk("release_ready", 64'(bus.child_ready), 64'd1);
        chk("hold_best", 64'(bus.best_score), 64'd200);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{64'h0000_0000_0000_0001, 32'd10, 4'd1, 32'd10, 64'h0000_0000_0000_0001};
        tbl[1] = '{64'h0000_0000_0000_0002, 32'd20, 4'd2, 32'd20, 64'h0000_0000_0000_0002};
        tbl[2] = '{64'h0000_0000_0000_0004, 32'd30, 4'd3, 32'd30, 64'h0000_0000_0000_0004};
        tbl[3] = '{64'h0000_0000_0000_0010, 32'd40, 4'd4, 32'd40, 64'h0000_0000_0000_0010};
        tbl[4] = '{64'h0000_0000_0000_0020, 32'd50, 4'd5, 32'd50, 64'h0000_0000_0000_0020};
        tbl[5] = '{64'h5555_5555_5555_5555, 32'd60, 4'd6, 32'd60, 64'h5555_5555_5555_5555};
        tbl[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 32'd70, 4'd7, 32'd70, 64'hAAAA_AAAA_AAAA_AAAA};
        tbl[7] = '{64'h1248_1248_1248_1248, 32'd80, 4'd8, 32'd80, 64'h1248_1248_1248_1248};

        bus.child_valid   = 1'b0;
        bus.child_weights = '0;
        bus.child_score   = '0;
        bus.parent_ready  = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_child_ready", 64'(bus.child_ready), 64'd0);
        chk("rst_parent_valid", 64'(bus.parent_valid), 64'd0);
        chk("rst_pop_count", 64'(bus.pop_count), 64'd0);
        chk("rst_best_score", 64'(bus.best_score), 64'd0);
        chk("rst_best_w", bus.best_weights, 64'd0);
        chk("rst_pa", bus.parent_weights_a, 64'd0);
        chk("rst_pb", bus.parent_weights_b, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(bus.child_ready), 64'd1);

        for (int i = 0; i < PS; i++) begin
            bus.child_valid   = 1'b1;
            bus.child_weights = tbl[i].w;
            bus.child_score   = tbl[i].s;
            @(negedge clk);
            chk("fill_count", 64'(bus.pop_count), 64'(tbl[i].cnt));
            chk("fill_best_s", 64'(bus.best_score), 64'(tbl[i].bs));
            chk("fill_best_w", bus.best_weights, tbl[i].bw);
            chk("fill_ready", 64'(bus.child_ready), 64'd1);
            m_w[i] = tbl[i].w;
            m_s[i] = tbl[i].s;
        end

        // Reject: score 5 is below every member.
        send_child(64'h0000_0000_0000_0A00, 32'd5);
        for (int k = 0; k < PS + 1; k++) begin
            chk("reject_busy", 64'(bus.child_ready), 64'd0);
            @(negedge clk);
        end
        chk("reject_ready_back", 64'(bus.child_ready), 64'd1);
        chk("reject_count", 64'(bus.pop_count), 64'd8);
        chk("reject_best", 64'(bus.best_score), 64'd80);

        // Replace slot 0 (score 10).
        send_child(64'h0000_0000_0000_0100, 32'd100);
        wait_idle();
        m_w[0] = 64'h0000_0000_0000_0100; m_s[0] = 32'd100;
        chk("replace_best_s", 64'(bus.best_score), 64'd100);
        chk("replace_best_w", bus.best_weights, 64'h0000_0000_0000_0100);
        chk("replace_count", 64'(bus.pop_count), 64'd8);

        // Equal to the minimum: discarded.
        send_child(64'h0000_0000_0000_0200, 32'd20);
        wait_idle();
        chk("equal_discard_best", 64'(bus.best_score), 64'd100);

        // 30 replaces slot 1; then 35 hits the 30/30 tie and takes slot 1 again.
        send_child(64'h0000_0000_0000_0400, 32'd30);
        wait_idle();
        m_w[1] = 64'h0000_0000_0000_0400; m_s[1] = 32'd30;
        send_child(64'h0000_0000_0000_0800, 32'd35);
        wait_idle();
        m_w[1] = 64'h0000_0000_0000_0800; m_s[1] = 32'd35;
        chk("tie_best", 64'(bus.best_score), 64'd100);

        // Sanitize: all-11 trits stored as zeros; minimum is now slot 2 (30).
        send_child(64'hFFFF_FFFF_FFFF_FFFF, 32'd200);
        wait_idle();
        m_w[2] = 64'h5555_5555_5555_5555; m_s[2] = 32'd200;
        chk("san_best_s", 64'(bus.best_score), 64'd200);
        chk("san_best_w", bus.best_weights, 64'h5555_5555_5555_5555);

        do_select();
        do_select();

        // Reset on the 4th SCAN cycle.
        send_child(64'h0000_0000_0000_0001, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midscan_count", 64'(bus.pop_count), 64'd0);
        chk("midscan_best_s", 64'(bus.best_score), 64'd0);
        chk("midscan_best_w", bus.best_weights, 64'd0);
        chk("midscan_valid", 64'(bus.parent_valid), 64'd0);
        chk("midscan_ready", 64'(bus.child_ready), 64'd0);
        chk("midscan_pa", bus.parent_weights_a, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midscan_ready_back", 64'(bus.child_ready), 64'd1);

        // First write into an empty population sets best even with score 0.
        bus.child_valid = 1'b1; bus.child_weights = 64'h9; bus.child_score = 32'd0;
        @(negedge clk);
        chk("zero_first_count", 64'(bus.pop_count), 64'd1);
        chk("zero_first_best_w", bus.best_weights, 64'h9);
        bus.child_weights = 64'h6;
        @(negedge clk);
        bus.child_valid = 1'b0;
        chk("zero_second_count", 64'(bus.pop_count), 64'd2);
        chk("zero_second_best_w", bus.best_weights, 64'h9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
